// File: rtl/sc_screen_sequencer.sv
// Game-level screen sequencer: tracks lives lost / levels won, times death and end screens.
// Optional macro SC_SCREENSEQ_AUTORESTART_EN: an expired hold restarts play instead of idling.
module sc_screen_sequencer #(
  parameter int unsigned LIVES       = 2,
  parameter int unsigned LEVELS      = 3,
  parameter int unsigned DEATH_TICKS = 4,
  parameter int unsigned HOLD_TICKS  = 8
) (
  input  logic       SC_SCREENSEQ_CLOCK_50,
  input  logic       SC_SCREENSEQ_RESET_InLow,
  input  logic       SC_SCREENSEQ_TICK_In,
  input  logic       SC_SCREENSEQ_START_In,
  input  logic       SC_SCREENSEQ_HIT_In,
  input  logic       SC_SCREENSEQ_GOAL_In,
  output logic [2:0] SC_SCREENSEQ_LOSE_Out,
  output logic [3:0] SC_SCREENSEQ_WIN_Out,
  output logic [2:0] SC_SCREENSEQ_STATE_Out,
  output logic       SC_SCREENSEQ_FREEZE_Out,
  output logic       SC_SCREENSEQ_RESPAWN_Out
);

  localparam int unsigned MaxTicks = (DEATH_TICKS > HOLD_TICKS) ? DEATH_TICKS : HOLD_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);

  localparam logic [2:0]      LivesC    = 3'(LIVES);
  localparam logic [3:0]      LevelsC   = 4'(LEVELS);
  localparam logic [CntW-1:0] DeathLast = CntW'(DEATH_TICKS - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StDying    = 3'd2,
    StLoseHold = 3'd3,
    StWinHold  = 3'd4
  } state_e;

  state_e          state_q;
  logic [2:0]      lose_q;
  logic [3:0]      win_q;
  logic [CntW-1:0] cnt_q;
  logic            freeze_q;
  logic            respawn_q;

  logic [2:0] lose_inc;
  logic [3:0] win_inc;

  // Saturating increments so the mux selects can never wrap.
  assign lose_inc = (lose_q >= LivesC) ? LivesC : lose_q + 3'd1;
  assign win_inc  = (win_q >= LevelsC) ? LevelsC : win_q + 4'd1;

  always_ff @(posedge SC_SCREENSEQ_CLOCK_50 or negedge SC_SCREENSEQ_RESET_InLow) begin
    if (!SC_SCREENSEQ_RESET_InLow) begin
      state_q   <= StIdle;
      lose_q    <= 3'd0;
      win_q     <= 4'd0;
      cnt_q     <= '0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      case (state_q)
        StIdle: begin
          freeze_q <= 1'b1;
          if (SC_SCREENSEQ_START_In) begin
            state_q   <= StPlay;
            lose_q    <= 3'd0;
            win_q     <= 4'd0;
            cnt_q     <= '0;
            freeze_q  <= 1'b0;
            respawn_q <= 1'b1;
          end
        end
        StPlay: begin
          freeze_q <= 1'b0;
          // A hit takes priority; a simultaneous goal is dropped.
          if (SC_SCREENSEQ_HIT_In) begin
            lose_q   <= lose_inc;
            cnt_q    <= '0;
            freeze_q <= 1'b1;
            state_q  <= (lose_inc == LivesC) ? StLoseHold : StDying;
          end else if (SC_SCREENSEQ_GOAL_In) begin
            win_q <= win_inc;
            if (win_inc == LevelsC) begin
              state_q  <= StWinHold;
              cnt_q    <= '0;
              freeze_q <= 1'b1;
            end else begin
              respawn_q <= 1'b1;
            end
          end
        end
        StDying: begin
          freeze_q <= 1'b1;
          if (SC_SCREENSEQ_TICK_In) begin
            if (cnt_q == DeathLast) begin
              state_q   <= StPlay;
              cnt_q     <= '0;
              freeze_q  <= 1'b0;
              respawn_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StLoseHold, StWinHold: begin
          freeze_q <= 1'b1;
          if (SC_SCREENSEQ_TICK_In) begin
            if (cnt_q == HoldLast) begin
              lose_q <= 3'd0;
              win_q  <= 4'd0;
              cnt_q  <= '0;
`ifdef SC_SCREENSEQ_AUTORESTART_EN
              state_q   <= StPlay;
              freeze_q  <= 1'b0;
              respawn_q <= 1'b1;
`else
              state_q   <= StIdle;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          lose_q   <= 3'd0;
          win_q    <= 4'd0;
          cnt_q    <= '0;
          freeze_q <= 1'b1;
        end
      endcase
    end
  end

  assign SC_SCREENSEQ_STATE_Out   = state_q;
  assign SC_SCREENSEQ_LOSE_Out    = lose_q;
  assign SC_SCREENSEQ_WIN_Out     = win_q;
  assign SC_SCREENSEQ_FREEZE_Out  = freeze_q;
  assign SC_SCREENSEQ_RESPAWN_Out = respawn_q;

endmodule

// File: tb/tb_sc_screen_sequencer.sv
// Directed table-driven bench for sc_screen_sequencer (default parameters).
module tb_sc_screen_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick, start, hit, goal;
  logic [2:0] lose_o;
  logic [3:0] win_o;
  logic [2:0] state_o;
  logic       freeze_o;
  logic       respawn_o;

  int n_checks = 0;
  int n_fail   = 0;

  sc_screen_sequencer dut (
    .SC_SCREENSEQ_CLOCK_50   (clk),
    .SC_SCREENSEQ_RESET_InLow(rst_n),
    .SC_SCREENSEQ_TICK_In    (tick),
    .SC_SCREENSEQ_START_In   (start),
    .SC_SCREENSEQ_HIT_In     (hit),
    .SC_SCREENSEQ_GOAL_In    (goal),
    .SC_SCREENSEQ_LOSE_Out   (lose_o),
    .SC_SCREENSEQ_WIN_Out    (win_o),
    .SC_SCREENSEQ_STATE_Out  (state_o),
    .SC_SCREENSEQ_FREEZE_Out (freeze_o),
    .SC_SCREENSEQ_RESPAWN_Out(respawn_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       t, s, h, g;
    logic [2:0] st;
    logic [2:0] lose;
    logic [3:0] win;
    logic       frz;
    logic       rsp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic t, s, h, g, input logic [2:0] st, lose,
                              input logic [3:0] win, input logic frz, rsp);
    vec_t v;
    v.t = t; v.s = s; v.h = h; v.g = g;
    v.st = st; v.lose = lose; v.win = win; v.frz = frz; v.rsp = rsp;
    return v;
  endfunction

  // Apply inputs for exactly one rising edge, then sample 1 time unit after it.
  task automatic drive(input logic t, s, h, g);
    @(negedge clk);
    tick = t; start = s; hit = h; goal = g;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] st, lose,
                            input logic [3:0] win, input logic frz, rsp);
    n_checks++;
    if (state_o !== st || lose_o !== lose || win_o !== win || freeze_o !== frz ||
        respawn_o !== rsp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d lose=%0d win=%0d freeze=%0b respawn=%0b, want state=%0d lose=%0d win=%0d freeze=%0b respawn=%0b",
               name, state_o, lose_o, win_o, freeze_o, respawn_o, st, lose, win, frz, rsp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; hit = 1'b0; goal = 1'b0;
    #1;
    expect_out("reset_values", 3'd0, 3'd0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; hit = 1'b0; goal = 1'b0;

    // Lose path:          t  s  h  g   st  lose win frz rsp
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, 3'd0, 4'd0, 1, 0)); // tick in idle
    vecs.push_back(mk(0, 0, 1, 1, 3'd0, 3'd0, 4'd0, 1, 0)); // hit/goal in idle
    vecs.push_back(mk(0, 1, 0, 0, 3'd1, 3'd0, 4'd0, 0, 1)); // start
    vecs.push_back(mk(0, 0, 0, 0, 3'd1, 3'd0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3'd1, 3'd0, 4'd0, 0, 0)); // start in play
    vecs.push_back(mk(0, 0, 1, 0, 3'd2, 3'd1, 4'd0, 1, 0)); // first hit
    vecs.push_back(mk(0, 0, 1, 0, 3'd2, 3'd1, 4'd0, 1, 0)); // hit in dying
    vecs.push_back(mk(0, 1, 0, 1, 3'd2, 3'd1, 4'd0, 1, 0)); // start/goal in dying
    vecs.push_back(mk(1, 0, 0, 0, 3'd2, 3'd1, 4'd0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'd2, 3'd1, 4'd0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'd2, 3'd1, 4'd0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'd1, 3'd1, 4'd0, 0, 1)); // 4th tick respawns
    vecs.push_back(mk(0, 0, 0, 1, 3'd1, 3'd1, 4'd1, 0, 1)); // goal 1
    vecs.push_back(mk(1, 0, 0, 0, 3'd1, 3'd1, 4'd1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3'd1, 3'd1, 4'd2, 0, 1)); // goal 2
    vecs.push_back(mk(1, 0, 0, 0, 3'd1, 3'd1, 4'd2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3'd3, 3'd2, 4'd2, 1, 0)); // second hit -> lose hold
    vecs.push_back(mk(0, 0, 1, 1, 3'd3, 3'd2, 4'd2, 1, 0)); // hit/goal in hold
    vecs.push_back(mk(0, 1, 0, 0, 3'd3, 3'd2, 4'd2, 1, 0)); // start in hold
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, 0, 0, 3'd3, 3'd2, 4'd2, 1, 0));
`ifdef SC_SCREENSEQ_AUTORESTART_EN
    vecs.push_back(mk(1, 0, 0, 0, 3'd1, 3'd0, 4'd0, 0, 1));
`else
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, 3'd0, 4'd0, 1, 0));
`endif

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].t, vecs[i].s, vecs[i].h, vecs[i].g);
      expect_out($sformatf("lose_path_vec%0d", i), vecs[i].st, vecs[i].lose, vecs[i].win,
                 vecs[i].frz, vecs[i].rsp);
    end

    // Win path with extra goal and start during the hold.
    do_reset();
    drive(0, 1, 0, 0); expect_out("win_start", 3'd1, 3'd0, 4'd0, 1'b0, 1'b1);
    drive(0, 0, 0, 1); expect_out("win_goal1", 3'd1, 3'd0, 4'd1, 1'b0, 1'b1);
    drive(1, 0, 0, 0); expect_out("win_tick1", 3'd1, 3'd0, 4'd1, 1'b0, 1'b0);
    drive(0, 0, 0, 1); expect_out("win_goal2", 3'd1, 3'd0, 4'd2, 1'b0, 1'b1);
    drive(1, 0, 0, 0); expect_out("win_tick2", 3'd1, 3'd0, 4'd2, 1'b0, 1'b0);
    drive(0, 0, 0, 1); expect_out("win_goal3", 3'd4, 3'd0, 4'd3, 1'b1, 1'b0);
    drive(0, 0, 0, 1); expect_out("win_extra_goal", 3'd4, 3'd0, 4'd3, 1'b1, 1'b0);
    drive(0, 1, 0, 0); expect_out("win_hold_start", 3'd4, 3'd0, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0);
      expect_out($sformatf("win_hold_tick%0d", i), 3'd4, 3'd0, 4'd3, 1'b1, 1'b0);
    end
    drive(1, 0, 0, 0);
`ifdef SC_SCREENSEQ_AUTORESTART_EN
    expect_out("win_hold_expire", 3'd1, 3'd0, 4'd0, 1'b0, 1'b1);
`else
    expect_out("win_hold_expire", 3'd0, 3'd0, 4'd0, 1'b1, 1'b0);
`endif

    // Simultaneous hit and goal: hit wins.
    do_reset();
    drive(0, 1, 0, 0); expect_out("both_start", 3'd1, 3'd0, 4'd0, 1'b0, 1'b1);
    drive(0, 0, 1, 1); expect_out("both_hit_goal", 3'd2, 3'd1, 4'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-play, checked before any further clock edge.
    do_reset();
    drive(0, 1, 0, 0); expect_out("async_pre", 3'd1, 3'd0, 4'd0, 1'b0, 1'b1);
    drive(0, 0, 0, 1); expect_out("async_goal", 3'd1, 3'd0, 4'd1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset_mid_play", 3'd0, 3'd0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0); expect_out("after_async_reset", 3'd0, 3'd0, 4'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
